// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller: FSM encodings, default
// sizes and the source/destination register match rule.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2,
        ST_RSVD     = 2'd3
    } ctrl_state_t;

    localparam int DEFAULT_MEM_TIMEOUT = 16;
    localparam int DEFAULT_CNT_W       = 16;
    localparam int REG_W               = 4;
    // Wide enough for the largest legal timeout (255).
    localparam int WAIT_W              = 8;

    function automatic logic src_match(
        input logic [REG_W-1:0] src_1,
        input logic [REG_W-1:0] src_2,
        input logic             two_src,
        input logic [REG_W-1:0] dest
    );
        return (src_1 == dest) || (two_src && (src_2 == dest));
    endfunction

endpackage

// File: rtl/hazard_detector.sv
// Combinational data-hazard detection for the instruction in ID against the
// instructions in EX and MEM, with and without a forwarding unit.
module hazard_detector
    import pipeline_ctrl_pkg::*;
(
    input  logic             i_Forwarding_Enable,
    input  logic [REG_W-1:0] i_Src_1,
    input  logic [REG_W-1:0] i_Src_2,
    input  logic             i_Two_Src,
    input  logic [REG_W-1:0] i_EXE_Destination,
    input  logic             i_EXE_Write_Back_Enable,
    input  logic             i_EXE_Memory_Read,
    input  logic [REG_W-1:0] i_MEM_Destination,
    input  logic             i_MEM_Write_Back_Enable,
    output logic             o_Hazard
);

    logic w_exe_match;
    logic w_mem_match;

    assign w_exe_match = src_match(i_Src_1, i_Src_2, i_Two_Src, i_EXE_Destination);
    assign w_mem_match = src_match(i_Src_1, i_Src_2, i_Two_Src, i_MEM_Destination);

    // With forwarding only a load in EX cannot be bypassed in time.
    always_comb begin
        if (i_Forwarding_Enable) begin
            o_Hazard = i_EXE_Memory_Read && w_exe_match;
        end else begin
            o_Hazard = (i_EXE_Write_Back_Enable && w_exe_match) ||
                       (i_MEM_Write_Back_Enable && w_mem_match);
        end
    end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Pipeline freeze/flush/bubble controller with a memory-wait FSM and timeout.
// Optional saturating stall-cycle counter enabled by defining STALL_COUNTER_EN.
module pipeline_stall_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT,
    parameter int CNT_W       = DEFAULT_CNT_W
) (
    input  logic             i_Clock,
    input  logic             i_Reset,
    input  logic             i_Forwarding_Enable,
    input  logic [REG_W-1:0] i_Src_1,
    input  logic [REG_W-1:0] i_Src_2,
    input  logic             i_Two_Src,
    input  logic [REG_W-1:0] i_EXE_Destination,
    input  logic             i_EXE_Write_Back_Enable,
    input  logic             i_EXE_Memory_Read,
    input  logic [REG_W-1:0] i_MEM_Destination,
    input  logic             i_MEM_Write_Back_Enable,
    input  logic             i_Branch_Taken,
    input  logic             i_Mem_Request,
    input  logic             i_Mem_Ready,
    output logic             o_Freeze_PC,
    output logic             o_Freeze_IF_ID,
    output logic             o_Freeze_EX_MEM,
    output logic             o_Flush_IF_ID,
    output logic             o_Bubble_ID_EX,
    output logic [1:0]       o_State,
    output logic             o_Mem_Error
`ifdef STALL_COUNTER_EN
    ,
    output logic [CNT_W-1:0] o_Stall_Count
`endif
);

    localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

    ctrl_state_t       r_state;
    ctrl_state_t       w_state_next;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [WAIT_W-1:0] w_wait_next;
    logic [WAIT_W-1:0] w_wait_inc;
    logic              w_mem_stall;
    logic              w_hazard;

    hazard_detector u_hazard_detector (
        .i_Forwarding_Enable     (i_Forwarding_Enable),
        .i_Src_1                 (i_Src_1),
        .i_Src_2                 (i_Src_2),
        .i_Two_Src               (i_Two_Src),
        .i_EXE_Destination       (i_EXE_Destination),
        .i_EXE_Write_Back_Enable (i_EXE_Write_Back_Enable),
        .i_EXE_Memory_Read       (i_EXE_Memory_Read),
        .i_MEM_Destination       (i_MEM_Destination),
        .i_MEM_Write_Back_Enable (i_MEM_Write_Back_Enable),
        .o_Hazard                (w_hazard)
    );

    assign w_mem_stall = i_Mem_Request && !i_Mem_Ready;
    assign w_wait_inc  = r_wait_cnt + WAIT_W'(1);
    assign o_State     = r_state;

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_wait_next     = r_wait_cnt;
        o_Freeze_PC     = 1'b0;
        o_Freeze_IF_ID  = 1'b0;
        o_Freeze_EX_MEM = 1'b0;
        o_Flush_IF_ID   = 1'b0;
        o_Bubble_ID_EX  = 1'b0;
        o_Mem_Error     = 1'b0;

        case (r_state)
            ST_RUN, ST_MEM_WAIT: begin
                if (w_mem_stall) begin
                    // A pending memory access outranks branches and hazards.
                    o_Freeze_PC     = 1'b1;
                    o_Freeze_IF_ID  = 1'b1;
                    o_Freeze_EX_MEM = 1'b1;
                    if (r_state == ST_RUN) begin
                        w_state_next = ST_MEM_WAIT;
                        w_wait_next  = WAIT_W'(1);
                    end else if (w_wait_inc >= TIMEOUT_V) begin
                        w_state_next = ST_ERROR;
                        w_wait_next  = w_wait_inc;
                    end else begin
                        w_wait_next  = w_wait_inc;
                    end
                end else begin
                    w_state_next = ST_RUN;
                    w_wait_next  = '0;
                    if (i_Branch_Taken) begin
                        // The wrong-path instruction in ID is discarded, so its hazard is moot.
                        o_Flush_IF_ID  = 1'b1;
                        o_Bubble_ID_EX = 1'b1;
                    end else if (w_hazard) begin
                        o_Freeze_PC    = 1'b1;
                        o_Freeze_IF_ID = 1'b1;
                        o_Bubble_ID_EX = 1'b1;
                    end
                end
            end
            ST_ERROR: begin
                o_Freeze_PC     = 1'b1;
                o_Freeze_IF_ID  = 1'b1;
                o_Freeze_EX_MEM = 1'b1;
                o_Bubble_ID_EX  = 1'b1;
                o_Mem_Error     = 1'b1;
            end
            default: begin
                w_state_next = ST_RUN;
                w_wait_next  = '0;
            end
        endcase
    end

`ifdef STALL_COUNTER_EN
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_stall_cnt <= '0;
        end else if (o_Freeze_PC && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign o_Stall_Count = r_stall_cnt;
`endif

endmodule

// File: doc/pipeline_stall_controller.md
PIPELINE_STALL_CONTROLLER -- requirements
Module: pipeline_stall_controller

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16, is the number of consecutive memory-wait cycles before an error is declared (legal range 2..255).
REQ-002 Parameter CNT_W, default 16, is the width of the stall-cycle counter.
REQ-003 The clock and reset ports SHALL be: i_Clock input 1 system clock; i_Reset input 1, asynchronous, active-high reset.
REQ-004 i_Forwarding_Enable input 1: the forwarding unit is active.
REQ-005 i_Src_1, i_Src_2 input 4 each: source registers of the instruction in ID.
REQ-006 i_Two_Src input 1: i_Src_2 is a real operand of the instruction in ID.
REQ-007 i_EXE_Destination input 4, i_EXE_Write_Back_Enable input 1, i_EXE_Memory_Read input 1: the instruction in EX.
REQ-008 i_MEM_Destination input 4, i_MEM_Write_Back_Enable input 1: the instruction in MEM.
REQ-009 i_Branch_Taken input 1: the branch resolved in EX is taken.
REQ-010 i_Mem_Request input 1, i_Mem_Ready input 1: data-memory access handshake.
REQ-011 Freeze outputs, each output 1: o_Freeze_PC, o_Freeze_IF_ID, o_Freeze_EX_MEM (also holds MEM/WB).
REQ-012 Flush/bubble outputs, each output 1: o_Flush_IF_ID; o_Bubble_ID_EX inserts a NOP into ID/EX.
REQ-013 Status outputs: o_State output 2 (the FSM state); o_Mem_Error output 1 (sticky error).

Function
REQ-014 The FSM SHALL have states RUN=2'd0, MEM_WAIT=2'd1 and ERROR=2'd2; the encoding 2'd3 SHALL recover to RUN.
REQ-015 mem_stall SHALL equal i_Mem_Request AND NOT i_Mem_Ready; it is combinational and applies in RUN and MEM_WAIT.
REQ-016 When mem_stall is high, all three freeze outputs SHALL be 1, both flush/bubble outputs SHALL be 0, and branch and hazard handling SHALL be deferred.
REQ-017 In RUN, mem_stall SHALL move the FSM to MEM_WAIT and load the wait counter with 1.
REQ-018 In MEM_WAIT, mem_stall SHALL increment the wait counter, and i_Mem_Ready SHALL return the FSM to RUN with the freeze released in that same cycle.
REQ-019 If the wait counter reaches MEM_TIMEOUT while mem_stall is still high, the FSM SHALL move to ERROR.
REQ-020 In ERROR, all freezes SHALL be 1, o_Bubble_ID_EX SHALL be 1 and o_Mem_Error SHALL be 1, held until reset, regardless of inputs.
REQ-021 Without mem_stall, i_Branch_Taken SHALL make o_Flush_IF_ID=1 and o_Bubble_ID_EX=1 in the same cycle, and hazard detection SHALL be suppressed.
REQ-022 A source match SHALL be (i_Src_1 == D) OR (i_Two_Src AND i_Src_2 == D).
REQ-023 With forwarding enabled, a hazard SHALL exist only when i_EXE_Memory_Read is high and the EXE destination matches (load-use).
REQ-024 With forwarding disabled, a hazard SHALL exist when EXE write-back is enabled with an EXE match, or MEM write-back is enabled with a MEM match.
REQ-025 A hazard with no mem_stall and no branch SHALL assert o_Freeze_PC=1, o_Freeze_IF_ID=1 and o_Bubble_ID_EX=1, with o_Freeze_EX_MEM=0.
REQ-026 A load-use hazard SHALL resolve after exactly one bubble cycle.
REQ-027 Outputs are combinational from the state and inputs; the only internal registers are the state, the wait counter and the counter under REQ-030.

Reset
REQ-028 On i_Reset: state RUN, wait counter 0, o_Mem_Error=0, stall counter 0.
REQ-029 Reset asserted during MEM_WAIT or ERROR SHALL return the block to RUN immediately, without waiting for a clock edge.

Configuration
REQ-030 With STALL_COUNTER_EN defined, the block SHALL add output o_Stall_Count [CNT_W-1:0], incremented every cycle in which o_Freeze_PC=1 and saturating at all-ones.
REQ-031 With STALL_COUNTER_EN undefined, the port and the counter SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-032 The state encodings and the default MEM_TIMEOUT SHALL reside in the shared package pipeline_ctrl_pkg.
REQ-033 Hazard detection SHALL be the sub-module hazard_detector, purely combinational, producing a 1-bit hazard flag.

Verification
REQ-034 Forwarding enabled; EXE is LDR R3 with memory read; ID uses Src_1=3 -> exactly one cycle of o_Bubble_ID_EX=1 and o_Freeze_PC=1, then a clean RUN.
REQ-035 Forwarding disabled; MEM write-back enabled to R5; Src_2=5 with i_Two_Src=0 -> no stall; the same with i_Two_Src=1 -> stall.
REQ-036 i_Mem_Request=1 with i_Mem_Ready low for 4 cycles -> o_State=MEM_WAIT and freezes high for 4 cycles, released in the cycle i_Mem_Ready rises.
REQ-037 i_Mem_Ready held low for 16 cycles -> o_State=ERROR and o_Mem_Error=1 sticky; i_Reset pulse -> RUN and o_Mem_Error=0.
REQ-038 i_Branch_Taken together with a hazard -> flush and bubble only, with no PC freeze; the same during mem_stall -> freeze only.
REQ-039 With STALL_COUNTER_EN defined, 3 stall cycles -> o_Stall_Count=3; forcing the counter to all-ones -> it holds at all-ones.
